// File: rtl/hs_mem_sdpram_1clk_pipe.sv
// Single-clock 1W/1R RAM with byte-enable writes, tracked read-valid and a RD_LATENCY-deep read pipeline.
// Latency: ren at edge T -> rvalid/rdata in the cycle after edge T+RD_LATENCY-1.
// Backpressure: none; one read and one write accepted every cycle.
module hs_mem_sdpram_1clk_pipe #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 16,
    parameter  int RD_LATENCY = 2,
    parameter  int RDW_MODE   = 0,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   wbe,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [RD_LATENCY-1:0] vld;
    logic [DATA_WIDTH-1:0] dat [RD_LATENCY];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  w_in_range;
    logic                  r_in_range;

    // Widen before comparing so a power-of-2 depth does not truncate to zero.
    assign w_in_range = (32'(waddr) < 32'(DATA_DEPTH));
    assign r_in_range = (32'(raddr) < 32'(DATA_DEPTH));

    always_ff @(posedge clk) begin
        if (wen && w_in_range) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem[raddr];
            // New-data mode: merge enabled lanes of a same-edge write into the returned word.
            if (RDW_MODE == 1 && wen && w_in_range && waddr == raddr) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
        end else begin
            vld[0] <= ren;
            if (ren) dat[0] <= rd_word;
            // Data stages only move with a valid token, so rdata holds between returns.
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign rvalid = vld[RD_LATENCY-1];
    assign rdata  = dat[RD_LATENCY-1];

endmodule

// File: tb/tb_hs_mem_sdpram_1clk_pipe.sv
// Bench for hs_mem_sdpram_1clk_pipe: four instances (latency 2/1/4, both RDW modes, depth 16 and 10)
// checked every cycle against a queue of expected returns.
module tb_hs_mem_sdpram_1clk_pipe;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        ren;
        logic [3:0]  raddr;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0, wbe = '0;
    logic [31:0] wdata = '0;
    logic        dwen = 1'b0, dren = 1'b0;
    logic [3:0]  dwaddr = '0, draddr = '0, dwbe = '0;
    logic [31:0] dwdata = '0;

    logic [31:0] rdata_v [4];
    logic        rvalid_v [4];

    int   lat [4] = '{2, 1, 4, 2};
    int   rdw [4] = '{0, 1, 0, 0};
    exp_t q [4][$];
    logic [31:0] last [4];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl [15];

    always #5 clk = ~clk;

    hs_mem_sdpram_1clk_pipe #(.DATA_WIDTH(32), .DATA_DEPTH(16), .RD_LATENCY(2), .RDW_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wbe(wbe), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rdata_v[0]), .rvalid(rvalid_v[0]));
    hs_mem_sdpram_1clk_pipe #(.DATA_WIDTH(32), .DATA_DEPTH(16), .RD_LATENCY(1), .RDW_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wbe(wbe), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rdata_v[1]), .rvalid(rvalid_v[1]));
    hs_mem_sdpram_1clk_pipe #(.DATA_WIDTH(32), .DATA_DEPTH(16), .RD_LATENCY(4), .RDW_MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wbe(wbe), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rdata_v[2]), .rvalid(rvalid_v[2]));
    hs_mem_sdpram_1clk_pipe #(.DATA_WIDTH(32), .DATA_DEPTH(10), .RD_LATENCY(2), .RDW_MODE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .waddr(dwaddr), .wdata(dwdata), .wbe(dwbe), .wen(dwen),
        .raddr(draddr), .ren(dren), .rdata(rdata_v[3]), .rvalid(rvalid_v[3]));

    task automatic push(input int k, input logic [31:0] e);
        exp_t x;
        x.due = cyc + lat[k];
        x.dat = e;
        q[k].push_back(x);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (q[k].size() > 0 && q[k][0].due == cyc) begin
                if (rvalid_v[k] !== 1'b1 || rdata_v[k] !== q[k][0].dat) begin
                    nerr++;
                    $display("FAIL %s inst%0d cyc%0d: rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                             tag, k, cyc, rvalid_v[k], rdata_v[k], q[k][0].dat);
                end
                last[k] = q[k][0].dat;
                void'(q[k].pop_front());
            end else if (rvalid_v[k] !== 1'b0 || rdata_v[k] !== last[k]) begin
                nerr++;
                $display("FAIL %s inst%0d cyc%0d: rvalid=%b rdata=%h, want rvalid=0 rdata=%h (held)",
                         tag, k, cyc, rvalid_v[k], rdata_v[k], last[k]);
            end
        end
    endtask

    // Inputs are set at the negedge; the next posedge is edge number cyc+1.
    task automatic tick(input string tag);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle();
        wen = 1'b0; ren = 1'b0; wbe = '0; dwen = 1'b0; dren = 1'b0; dwbe = '0;
    endtask

    task automatic flush_model();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = '0;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  32'h0,        32'h0};
        tbl[1]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  32'h0,        32'h0};
        tbl[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 4'd5,  32'h11223344, 4'hF, 1'b0, 4'd0,  32'h0,        32'h0};
        tbl[4]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'h5, 1'b0, 4'd0,  32'h0,        32'h0};
        tbl[5]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  32'h11BB33DD, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 4'd7,  32'h0,        4'hF, 1'b0, 4'd0,  32'h0,        32'h0};
        tbl[7]  = '{1'b1, 4'd7,  32'hCAFEF00D, 4'hF, 1'b1, 4'd7,  32'h0,        32'hCAFEF00D};
        tbl[8]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  32'hCAFEF00D, 32'hCAFEF00D};
        tbl[9]  = '{1'b1, 4'd9,  32'hFFFFFFFF, 4'h2, 1'b1, 4'd9,  32'h0000001B, 32'h0000FF1B};
        tbl[10] = '{1'b1, 4'd10, 32'h12345678, 4'hF, 1'b1, 4'd11, 32'h00000021, 32'h00000021};
        tbl[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd10, 32'h12345678, 32'h12345678};
        tbl[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd9,  32'h0000FF1B, 32'h0000FF1B};
        tbl[13] = '{1'b1, 4'd3,  32'h0,        4'h0, 1'b0, 4'd0,  32'h0,        32'h0};
        tbl[14] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF};

        flush_model();
        @(negedge clk);
        check_all("reset");
        tick("reset");
        rst_n = 1'b1;
        tick("post_reset");

        // Fill addresses 0..15 with addr*3, then stream them back-to-back.
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; waddr = 4'(i); wdata = 32'(i * 3); wbe = 4'hF;
            tick("fill");
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            ren = 1'b1; raddr = 4'(i);
            for (int k = 0; k < 3; k++) push(k, 32'(i * 3));
            tick("stream");
        end
        idle();
        for (int i = 0; i < 5; i++) tick("stream_drain");

        foreach (tbl[i]) begin
            wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata; wbe = tbl[i].wbe;
            ren = tbl[i].ren; raddr = tbl[i].raddr;
            if (tbl[i].ren) begin
                for (int k = 0; k < 3; k++) push(k, (rdw[k] == 1) ? tbl[i].exp_new : tbl[i].exp_old);
            end
            tick($sformatf("vec%0d", i));
        end
        idle();
        for (int i = 0; i < 5; i++) tick("tbl_drain");

        // Depth 10: address 12 is out of range for both write and read.
        dwen = 1'b1; dwaddr = 4'd9; dwdata = 32'h99; dwbe = 4'hF;
        tick("d_w9");
        dwaddr = 4'd12; dwdata = 32'h55;
        tick("d_w12");
        dwen = 1'b0; dren = 1'b1; draddr = 4'd9; push(3, 32'h99);
        tick("d_r9");
        draddr = 4'd12; push(3, 32'h0);
        tick("d_r12");
        idle();
        for (int i = 0; i < 3; i++) tick("d_drain");

        // Reset with reads in flight: outputs clear at once and the pending returns are lost.
        ren = 1'b1; raddr = 4'd5;
        for (int k = 0; k < 3; k++) push(k, 32'h11BB33DD);
        tick("pre_rst");
        idle();
        rst_n = 1'b0;
        #1;
        flush_model();
        check_all("rst_async");
        tick("in_rst");
        tick("in_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick("after_rst");
        ren = 1'b1; raddr = 4'd3;
        for (int k = 0; k < 3; k++) push(k, 32'hDEADBEEF);
        tick("retained");
        idle();
        for (int i = 0; i < 5; i++) tick("final_drain");

        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (q[k].size() != 0) begin
                nerr++;
                $display("FAIL drain inst%0d: %0d returns outstanding, want 0", k, q[k].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hs_mem_sdpram_1clk_pipe.md
Name: hs_mem_sdpram_1clk_pipe

Overview:
Single-clock simple dual-port RAM (1W/1R) with byte-enable writes, a configurable read pipeline and a selectable read-during-write policy. It is the parametrised successor of the team's dual-clock 1W/1R RAM and is intended for same-clock-domain buffers such as FIFOs, line buffers and descriptor tables. Unlike the dual-clock RAM, it adds a tracked read-valid output, guarded out-of-range addresses, reset of the output pipeline, and data forwarding on address collisions.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- DATA_DEPTH, 16: number of addressable words, 1 to 1048576; any value is legal, not only powers of 2.
- RD_LATENCY, 2: cycles from ren to rvalid/rdata, 1 to 4.
- RDW_MODE, 0: same-address read-during-write policy; 0 = old data, 1 = new data (forwarded).
- BE_WIDTH (localparam), DATA_WIDTH/8: number of byte-enable bits.
- ADDR_WIDTH (localparam), max(1, $clog2(DATA_DEPTH)): address width.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset, asynchronous and active-low; clears the read pipeline only, RAM array is not reset.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- wbe  input  BE_WIDTH  byte enables; bit i selects wdata[8i+7:8i].
- wen  input  1  write strobe.
- raddr  input  ADDR_WIDTH  read address.
- ren  input  1  read strobe.
- rdata  output  DATA_WIDTH  read data; valid when rvalid=1.
- rvalid  output  1  one-cycle pulse per accepted read.

Behaviour:
- Write: on a posedge with wen=1 and waddr<DATA_DEPTH, each byte lane with wbe[i]=1 is updated; other lanes are unchanged. A write with waddr>=DATA_DEPTH is dropped silently. wen=1 with wbe=0 changes nothing.
- Read: ren=1 at edge T captures raddr. rvalid=1 and rdata=word during the cycle after edge T+RD_LATENCY-1, so RD_LATENCY=1 matches the dual-clock RAM timing.
- Throughput: fully pipelined, one read per cycle, no stalls and no backpressure. No ready signals.
- Out-of-range read (raddr>=DATA_DEPTH): the read is still accepted, rvalid pulses, rdata=0.
- Valid tracking: a RD_LATENCY-deep shift register of valid bits; rvalid is the last stage.
- Data stages advance only when the corresponding valid bit is set. rdata holds the last returned word while rvalid=0.
- Read-during-write, same in-range address on the same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, with wdata on enabled lanes and old data on the others.
- Read-during-write, different addresses: no interaction.
- Read of an address written on an earlier edge always returns the written data in both modes.
- Reset (asserted asynchronously, at any time): rvalid=0, rdata=0, all pipeline valid and data stages cleared. In-flight reads are discarded, with no rvalid for them after release. RAM contents are retained.
- First edge after rst_n deasserts: reads and writes are accepted normally.
- Uninitialised words: contents undefined; the bench must write before reading.
- No state machine beyond the valid pipeline; the control is purely the shift and forward logic.

Test Plan:
- Basic latency (RD_LATENCY=2): write 0xDEADBEEF @3. Read @3 at cycle 10 -> rvalid=1 and rdata=0xDEADBEEF in cycle 12 only; rdata holds afterwards.
- Byte enables: write 0x11223344 @5, then wdata=0xAABBCCDD with wbe=4'b0101 @5, then read @5 -> 0x11BB33DD.
- Collision: word @7=0x0 at start; same edge wen @7 with 0xCAFEF00D and wbe=4'b1111, plus ren @7 -> RDW_MODE=0 returns 0x0, RDW_MODE=1 returns 0xCAFEF00D. A later read returns 0xCAFEF00D in both modes.
- Streaming: ren on 16 consecutive cycles, addr 0..15 holding value=addr*3 -> 16 consecutive rvalid pulses with rdata 0,3,...,45 in order. Repeat for RD_LATENCY=1 and 4.
- Non-power-of-2 depth (DATA_DEPTH=10): write 0x55 @12 is dropped and @9 is unchanged. Read @12 -> rvalid=1, rdata=0.
- Reset mid-flight: ren at cycle N, rst_n low at N+1 for 2 cycles -> rvalid and rdata go 0 immediately and no rvalid follows. Reading a pre-reset written address afterwards returns its original data.
